rr_arbiter8: RTL and testbench
==============================

Name: rr_arbiter8

Overview:
- Round-robin arbiter sharing one resource between 8 requesters.
- Output is a binary grant index plus a one-hot grant vector, produced by a 3-to-8 enable decoder instance.
- Sits in front of any shared datapath whose select lines are driven by our decoders; the arbiter sequences ownership.
- A requester holds the grant until it releases or a hold timeout expires.

Parameters:
- TIMEOUT, 16, maximum cycles a grant may be held (range 1..255); 0 disables the timeout.

Ports:
- Clock  input  1  system clock, rising edge.
- Resetn  input  1  asynchronous, active-low reset.
- req  input  8  request vector; bit i = requester i.
- done  input  1  release strobe from the current owner; sampled only in GRANT.
- busy  output  1  1 while in GRANT.
- gnt_idx  output  3  index of the current or last owner.
- gnt  output  8  one-hot grant; all zero when not busy.
- timeout  output  1  one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset (Resetn=0, asynchronous):
  - state=IDLE, ptr=0, gnt_idx=0, hold_cnt=0.
  - busy=0, gnt=8'b0, timeout=0.
- All outputs are registered, except gnt, which is decoded combinationally from the registered gnt_idx and busy.
- States: IDLE, GRANT.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the first set bit scanning ptr, ptr+1, ..., ptr+7 (mod 8).
  - At the clock edge: gnt_idx=winner, busy=1, hold_cnt=0, state=GRANT.
  - Latency: req high at edge k means gnt valid from edge k+1.
- GRANT:
  - Increment hold_cnt every cycle, saturating at 255.
  - Release at the edge when done=1 OR req[gnt_idx]=0.
  - Timeout revoke at the edge when TIMEOUT!=0 and hold_cnt==TIMEOUT-1 and no release; timeout=1 for the following cycle only.
  - On release or revoke: state=IDLE, busy=0, ptr=gnt_idx+1 (3-bit wrap, so 7 -> 0); gnt_idx keeps its value.
- After release there is always exactly one IDLE cycle before the next grant.
- Simultaneous done and timeout condition: treat as a normal release, with timeout=0.
- Requests from other requesters during GRANT are ignored; they are arbitrated in the next IDLE cycle.
- done while in IDLE is ignored.
- Resetn asserted mid-grant: gnt drops immediately (asynchronous), ptr returns to 0.
- Fairness: with all 8 requesting continuously, grants rotate 0,1,...,7,0,...; no requester waits more than 7 grants.

Decomposition:
- Shared package arb_pkg:
  - N_REQ=8, IDX_W=3, CNT_W=8.
  - State encoding ST_IDLE=1'b0, ST_GRANT=1'b1.
- Sub-module grant_dec3to8:
  - Ports: 3-bit w, En, 8-bit y.
  - En=0 gives y=0, not don't-care.
  - Built from two 2-to-4 enable decoders, with w[2] steering the enable.
- The priority scan is a function in the package (rotate right by ptr, find first one, add ptr back mod 8).

Test Plan:
- Reset:
  - Stimulus: Resetn=0 with req=8'hFF.
  - Required: gnt=0, busy=0, gnt_idx=0.
  - Then release reset, still req=8'hFF: gnt=8'h01 one cycle later.
- Rotation:
  - Stimulus: req=8'hFF; owner pulses done one cycle after each grant.
  - Required: gnt_idx sequence 0,1,2,...,7,0, with one IDLE cycle between grants.
- Wrap and skip:
  - Stimulus: ptr=6 (after a grant to 5 is released), then req=8'b0000_0101.
  - Required: winner is 0 (gnt=8'h01); after it releases, the next winner is 2.
- Drop release:
  - Stimulus: requester 3 granted, then req[3] drops without done.
  - Required: busy=0 at the next edge, ptr=4.
- Timeout (TIMEOUT=4):
  - Stimulus: req[5] held high, done never asserted.
  - Required: busy for exactly 4 cycles, then timeout pulses 1 cycle; requester 5 is re-granted only after the other active requesters.
- Async reset mid-grant:
  - Stimulus: Resetn low between edges while gnt=8'h10.
  - Required: gnt=0 immediately; after release, arbitration restarts from index 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared constants, state encoding and the rotating priority scan for the
// 8-way round-robin arbiter.
package arb_pkg;

   localparam int N_REQ = 8;
   localparam int IDX_W = 3;
   localparam int CNT_W = 8;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_t;

   // Rotate req right by ptr so ptr sits at bit 0, take the lowest set bit,
   // then add ptr back; the 3-bit sum wraps naturally mod 8.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                input logic [IDX_W-1:0] ptr);
      logic [2*N_REQ-1:0] dbl;
      logic [N_REQ-1:0]   rot;
      logic [IDX_W-1:0]   off;
      logic               found;
      dbl   = {req, req} >> ptr;
      rot   = dbl[N_REQ-1:0];
      off   = '0;
      found = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!found && rot[i]) begin
            off   = IDX_W'(i);
            found = 1'b1;
         end
      end
      return off + ptr;
   endfunction

endpackage

// File: rtl/grant_dec3to8.sv
// 3-to-8 enable decoder built from two 2-to-4 enable decoders; w[2] steers
// which half receives the enable. En=0 forces an all-zero output.
module dec2to4 (
   input  logic [1:0] w,
   input  logic       en,
   output logic [3:0] y
);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_out
         assign y[gi] = en && (w == 2'(gi));
      end
   endgenerate

endmodule

module grant_dec3to8 (
   input  logic [2:0] w,
   input  logic       En,
   output logic [7:0] y
);

   logic en_lo;
   logic en_hi;

   assign en_lo = En & ~w[2];
   assign en_hi = En &  w[2];

   dec2to4 u_lo (
      .w  (w[1:0]),
      .en (en_lo),
      .y  (y[3:0])
   );

   dec2to4 u_hi (
      .w  (w[1:0]),
      .en (en_hi),
      .y  (y[7:4])
   );

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with done/drop release and an
// optional hold timeout; gnt is decoded from the registered index and busy.
module rr_arbiter8
   import arb_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic             Clock,
   input  logic             Resetn,
   input  logic [N_REQ-1:0] req,
   input  logic             done,
   output logic             busy,
   output logic [IDX_W-1:0] gnt_idx,
   output logic [N_REQ-1:0] gnt,
   output logic             timeout
);

   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   arb_state_t       state_reg;
   logic [IDX_W-1:0] ptr_reg;
   logic [IDX_W-1:0] gnt_idx_reg;
   logic [CNT_W-1:0] hold_cnt_reg;
   logic             busy_reg;
   logic             timeout_reg;

   logic             release_now;
   logic             revoke_now;

   // A simultaneous release wins over the timeout, so no pulse in that case.
   assign release_now = done | ~req[gnt_idx_reg];
   assign revoke_now  = (TIMEOUT != 0) && (hold_cnt_reg == TO_LAST) && !release_now;

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_reg    <= ST_IDLE;
         ptr_reg      <= '0;
         gnt_idx_reg  <= '0;
         hold_cnt_reg <= '0;
         busy_reg     <= 1'b0;
         timeout_reg  <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               timeout_reg <= 1'b0;
               if (|req) begin
                  gnt_idx_reg  <= rr_pick(req, ptr_reg);
                  busy_reg     <= 1'b1;
                  hold_cnt_reg <= '0;
                  state_reg    <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (hold_cnt_reg != CNT_MAX)
                  hold_cnt_reg <= hold_cnt_reg + 8'd1;
               if (release_now || revoke_now) begin
                  state_reg   <= ST_IDLE;
                  busy_reg    <= 1'b0;
                  ptr_reg     <= gnt_idx_reg + 3'd1;
                  timeout_reg <= revoke_now;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   grant_dec3to8 u_dec (
      .w  (gnt_idx_reg),
      .En (busy_reg),
      .y  (gnt)
   );

   assign busy    = busy_reg;
   assign gnt_idx = gnt_idx_reg;
   assign timeout = timeout_reg;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8 (TIMEOUT=4): reset, rotation, wrap/skip,
// drop release, timeout and asynchronous reset mid-grant.
module tb_rr_arbiter8;

   logic       Clock;
   logic       Resetn;
   logic [7:0] req;
   logic       done;
   logic       busy;
   logic [2:0] gnt_idx;
   logic [7:0] gnt;
   logic       timeout;

   int total = 0;
   int bad   = 0;

   rr_arbiter8 #(.TIMEOUT(4)) dut (
      .Clock   (Clock),
      .Resetn  (Resetn),
      .req     (req),
      .done    (done),
      .busy    (busy),
      .gnt_idx (gnt_idx),
      .gnt     (gnt),
      .timeout (timeout)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp)
         else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         end
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      Resetn = 1'b0;
      req    = 8'hFF;
      done   = 1'b0;

      // Reset held with all requesting
      repeat (2) @(negedge Clock);
      chk("rst_gnt", gnt, 8'h00);
      chk("rst_busy", {7'd0, busy}, 8'd0);
      chk("rst_idx", {5'd0, gnt_idx}, 8'd0);
      chk("rst_tmo", {7'd0, timeout}, 8'd0);
      Resetn = 1'b1;
      @(negedge Clock);
      chk("first_gnt", gnt, 8'h01);

      // Rotation 0..7,0 with done one cycle after each grant
      for (int i = 0; i < 9; i++) begin
         chk($sformatf("rot_idx%0d", i), {5'd0, gnt_idx}, 8'(i % 8));
         chk($sformatf("rot_gnt%0d", i), gnt, 8'(1 << (i % 8)));
         done = 1'b1;
         @(negedge Clock);
         chk($sformatf("rot_gap%0d", i), {7'd0, busy}, 8'd0);
         chk($sformatf("rot_gapg%0d", i), gnt, 8'h00);
         done = 1'b0;
         if (i == 8) req = 8'h00;
         @(negedge Clock);
      end
      chk("idle_noreq", {7'd0, busy}, 8'd0);

      // Grant 5 (ptr=1), release by drop -> ptr=6, then wrap to 0 and skip to 2
      req = 8'h20;
      @(negedge Clock);
      chk("g5_idx", {5'd0, gnt_idx}, 8'd5);
      req = 8'b0000_0101;
      @(negedge Clock);
      chk("g5_rel", {7'd0, busy}, 8'd0);
      chk("g5_keep_idx", {5'd0, gnt_idx}, 8'd5);
      @(negedge Clock);
      chk("wrap_gnt", gnt, 8'h01);
      done = 1'b1;
      @(negedge Clock);
      done = 1'b0;
      @(negedge Clock);
      chk("skip_gnt", gnt, 8'h04);

      // Requester 3 granted, then drops its request without done
      req  = 8'h08;
      done = 1'b1;
      @(negedge Clock);
      done = 1'b0;
      @(negedge Clock);
      chk("g3_gnt", gnt, 8'h08);
      req = 8'h00;
      @(negedge Clock);
      chk("drop_busy", {7'd0, busy}, 8'd0);
      chk("drop_tmo", {7'd0, timeout}, 8'd0);

      // ptr=4: requesters 0,5,6 -> 5 wins; 5 then times out after 4 cycles
      req = 8'h61;
      @(negedge Clock);
      chk("to_g5", gnt, 8'h20);
      for (int c = 1; c < 4; c++) begin
         @(negedge Clock);
         chk($sformatf("to_busy%0d", c), {7'd0, busy}, 8'd1);
         chk($sformatf("to_nopulse%0d", c), {7'd0, timeout}, 8'd0);
      end
      @(negedge Clock);
      chk("to_rel", {7'd0, busy}, 8'd0);
      chk("to_pulse", {7'd0, timeout}, 8'd1);
      @(negedge Clock);
      chk("to_pulse_end", {7'd0, timeout}, 8'd0);
      chk("to_next6", gnt, 8'h40);
      done = 1'b1;
      @(negedge Clock);
      done = 1'b0;
      @(negedge Clock);
      chk("to_next0", gnt, 8'h01);
      done = 1'b1;
      @(negedge Clock);
      done = 1'b0;
      @(negedge Clock);
      chk("to_regrant5", gnt, 8'h20);

      // done coincides with the timeout edge: plain release, no pulse
      repeat (3) @(negedge Clock);
      chk("both_busy", {7'd0, busy}, 8'd1);
      done = 1'b1;
      @(negedge Clock);
      done = 1'b0;
      chk("both_rel", {7'd0, busy}, 8'd0);
      chk("both_tmo", {7'd0, timeout}, 8'd0);

      // ptr=6: only 4 requests -> gnt=8'h10, then async reset mid-grant
      req = 8'h10;
      @(negedge Clock);
      chk("ar_gnt", gnt, 8'h10);
      #2;
      Resetn = 1'b0;
      #1;
      chk("ar_gnt_drop", gnt, 8'h00);
      chk("ar_busy", {7'd0, busy}, 8'd0);
      chk("ar_idx", {5'd0, gnt_idx}, 8'd0);
      req = 8'h11;
      @(negedge Clock);
      Resetn = 1'b1;
      @(negedge Clock);
      chk("ar_restart", gnt, 8'h01);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
